// File: rtl/display_pkg.sv
// Shared segment encoding for the 7-segment display blocks.
// Bit order of every pattern: a[6] b[5] c[4] d[3] e[2] f[1] g[0], active-high.
package display_pkg;

  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_0     = 7'b1111110;
  localparam seg_pattern_t SEG_1     = 7'b0110000;
  localparam seg_pattern_t SEG_2     = 7'b1101101;
  localparam seg_pattern_t SEG_3     = 7'b1111001;
  localparam seg_pattern_t SEG_4     = 7'b0110011;
  localparam seg_pattern_t SEG_5     = 7'b1011011;
  localparam seg_pattern_t SEG_6     = 7'b1011111;
  localparam seg_pattern_t SEG_7     = 7'b1110000;
  localparam seg_pattern_t SEG_8     = 7'b1111111;
  localparam seg_pattern_t SEG_9     = 7'b1111011;
  localparam seg_pattern_t SEG_A     = 7'b1110111;
  localparam seg_pattern_t SEG_B     = 7'b0011111;
  localparam seg_pattern_t SEG_C     = 7'b1001110;
  localparam seg_pattern_t SEG_D     = 7'b0111101;
  localparam seg_pattern_t SEG_E     = 7'b1001111;
  localparam seg_pattern_t SEG_F     = 7'b1000111;
  localparam seg_pattern_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-segment decoder; active-high pattern out.
// In BCD mode nibbles 10..15 decode to blank.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0]   nibble,
  input  logic         modo_hex,
  output seg_pattern_t pattern
);

  // Look up the glyph, then suppress non-decimal values in BCD mode.
  always_comb begin
    // NOTE: pattern gets a default before the case so no path can leave it unassigned and infer a latch.
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
    if (!modo_hex && (nibble > 4'd9)) pattern = SEG_BLANK;
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed multi-digit 7-segment driver with double-buffered
// settings (pending/active), leading-zero blanking, decimal points and
// an inter-digit dark gap at the start of every slot.
module display_mux_7seg
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 100,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] valor,
  input  logic                    load,
  input  logic                    modo_hex,
  input  logic                    blank_zeros,
  input  logic [NUM_DIGITS-1:0]   pontos,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodo,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACT_LOW}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] valor;
    logic                    modo_hex;
    logic                    blank_zeros;
    logic [NUM_DIGITS-1:0]   pontos;
  } disp_set_t;

  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic             pre_end;
  logic             last_digit;
  logic             boundary;
  logic             lit;

  disp_set_t incoming;
  disp_set_t pending;
  disp_set_t active;
  logic      load_flag;

  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] an_sel;
  seg_pattern_t          dec_pat;
  seg_pattern_t          shown_pat;

  assign pre_end    = (pre == PRE_W'(SCAN_DIV - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary   = pre_end && last_digit;
  assign lit        = (pre >= PRE_W'(BLANK_CYC));
  assign incoming   = {valor, modo_hex, blank_zeros, pontos};

  // Slot prescaler and digit index; a frame is NUM_DIGITS slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
      pre <= '0;
      idx <= '0;
    end else if (pre_end) begin
      pre <= '0;
      idx <= last_digit ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Double buffer: loads land in pending; active only changes at a frame
  // boundary, so a frame never mixes two values. A load in the boundary
  // cycle itself goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both setting registers are reset; cleared settings display as all zeros.
      pending   <= '0;
      active    <= '0;
      load_flag <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        pending <= incoming;
        active  <= incoming;
      end else if (load_flag) begin
        active  <= pending;
      end
      load_flag <= 1'b0;
    end else if (load) begin
      pending   <= incoming;
      load_flag <= 1'b1;
    end
  end

  // Select the current digit's nibble, decimal point and anode, and work
  // out leading-zero blanking by scanning from the top digit down.
  always_comb begin
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    upper_zero = 1'b1;
    an_sel     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (active.valor[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        sel_nib   = active.valor[4*i +: 4];
        sel_dp    = active.pontos[i];
        sel_blank = active.blank_zeros && upper_zero && (i != 0);
        an_sel[i] = 1'b1;
      end
    end
  end

  seg_decoder u_seg_decoder (
    .nibble   (sel_nib),
    .modo_hex (active.modo_hex),
    .pattern  (dec_pat)
  );

  assign shown_pat = sel_blank ? SEG_BLANK : dec_pat;

  // Registered pin drivers: everything off during the dark gap, polarity
  // applied by XOR with the off level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= SEG_ACT_LOW;
      anodo      <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (lit) begin
        seg   <= shown_pat ^ SEG_OFF;
        dp    <= sel_dp ^ SEG_ACT_LOW;
        anodo <= an_sel ^ AN_OFF;
      end else begin
        seg   <= SEG_OFF;
        dp    <= SEG_ACT_LOW;
        anodo <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Bench for display_mux_7seg with a small scan (4 digits, 8-cycle slots,
// 2 dark cycles). Expected pins come from a model that keeps a log of
// loads with the scan state they occurred in and derives what each scan
// state must show from frame arithmetic.
module tb_display_mux_7seg;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] valor = '0;
  logic        load = 1'b0;
  logic        modo_hex = 1'b0;
  logic        blank_zeros = 1'b0;
  logic [3:0]  pontos = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anodo;
  logic        frame_done;

  display_mux_7seg #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC),
    .SEG_ACT_LOW(1'b1),
    .AN_ACT_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valor      (valor),
    .load       (load),
    .modo_hex   (modo_hex),
    .blank_zeros(blank_zeros),
    .pontos     (pontos),
    .seg        (seg),
    .dp         (dp),
    .anodo      (anodo),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;
    logic [15:0] v;
    logic        hx;
    logic        bz;
    logic [3:0]  p;
  } load_t;

  load_t       lq[$];
  int          st;
  int          tests = 0;
  int          failed = 0;
  logic [12:0] obs;
  logic [12:0] exp_v;

  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Pins {frame_done, seg, dp, anodo} expected just after the edge that leaves scan state s.
  function automatic logic [12:0] exp_out(int s);
    logic [15:0] v;
    logic        hx;
    logic        bz;
    logic [3:0]  p;
    logic [3:0]  nib;
    logic [6:0]  pat;
    int          pre;
    int          d;
    bit          lit;
    bit          fd;
    v = '0; hx = 1'b0; bz = 1'b0; p = '0;
    foreach (lq[i])
      if ((lq[i].s / FRAME) * FRAME + FRAME - 1 < s) begin
        v = lq[i].v; hx = lq[i].hx; bz = lq[i].bz; p = lq[i].p;
      end
    pre = s % SD;
    d   = (s / SD) % ND;
    lit = (pre >= BC);
    nib = 4'((v >> (4 * d)) & 16'hF);
    pat = tbl[nib];
    if (!hx && nib > 9) pat = 7'h00;
    if (bz && d > 0 && (v >> (4 * d)) == 0) pat = 7'h00;
    fd = ((s % FRAME) == FRAME - 1);
    return {fd, lit ? ~pat : 7'h7F, lit ? ~p[d] : 1'b1, lit ? ~(4'b0001 << d) : 4'hF};
  endfunction

  // One clock: drive inputs, log a load with the state it is sampled in, advance.
  task automatic step(input logic ld, input logic [15:0] v, input logic hx,
                      input logic bz, input logic [3:0] p);
    load_t e;
    load = ld; valor = v; modo_hex = hx; blank_zeros = bz; pontos = p;
    if (ld) begin
      e.s = st; e.v = v; e.hx = hx; e.bz = bz; e.p = p;
      lq.push_back(e);
    end
    @(posedge clk);
    st++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lq.delete();
    st = 0;
  endtask

  task automatic test_reset();
    st = 0;
    #12;
    obs = {frame_done, seg, dp, anodo};
    tests++;
    if (obs !== {1'b0, 7'h7F, 1'b1, 4'hF}) begin
      failed++;
      $display("FAIL reset_levels got %b required %b", obs, {1'b0, 7'h7F, 1'b1, 4'hF});
    end
    release_reset();
    for (int k = 0; k < 2 * FRAME + 6; k++) begin
      step(1'b0, valor, modo_hex, blank_zeros, pontos);
      if (k == 2) begin
        tests++;
        if (anodo !== 4'b1110) begin
          failed++;
          $display("FAIL first_lit_anode got %b required 1110", anodo);
        end
      end
      exp_v = exp_out(st - 1);
      obs = {frame_done, seg, dp, anodo};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL reset_scan state=%0d got %b required %b", st - 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_bcd();
    step(1'b1, 16'h1234, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      step(1'b0, valor, modo_hex, blank_zeros, pontos);
      exp_v = exp_out(st - 1);
      obs = {frame_done, seg, dp, anodo};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL bcd_1234 state=%0d got %b required %b", st - 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_hex_blank();
    for (int m = 0; m < 2; m++) begin
      step(1'b1, 16'h00A5, (m == 0), 1'b1, 4'b0000);
      for (int k = 0; k < 2 * FRAME + 4; k++) begin
        step(1'b0, valor, modo_hex, blank_zeros, pontos);
        exp_v = exp_out(st - 1);
        obs = {frame_done, seg, dp, anodo};
        tests++;
        if (obs !== exp_v) begin
          failed++;
          $display("FAIL hex_blank_00A5 mode=%0d state=%0d got %b required %b",
                   1 - m, st - 1, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_zero_dp();
    step(1'b1, 16'h0000, 1'b0, 1'b1, 4'b0100);
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      step(1'b0, valor, modo_hex, blank_zeros, pontos);
      exp_v = exp_out(st - 1);
      obs = {frame_done, seg, dp, anodo};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL zero_dp state=%0d got %b required %b", st - 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lim;
    lim = 0;
    // Align to early in a frame, then load 1111, 2222, and 3333 on the boundary.
    while (st % FRAME != 3 && lim < 2 * FRAME) begin
      step(1'b0, valor, modo_hex, blank_zeros, pontos);
      lim++;
    end
    step(1'b1, 16'h1111, 1'b0, 1'b0, 4'b0000);
    while (st % FRAME != 12) step(1'b0, valor, modo_hex, blank_zeros, pontos);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 4'b0000);
    while (st % FRAME != FRAME - 1) step(1'b0, valor, modo_hex, blank_zeros, pontos);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < FRAME + 8; k++) begin
      step(1'b0, valor, modo_hex, blank_zeros, pontos);
      exp_v = exp_out(st - 1);
      obs = {frame_done, seg, dp, anodo};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL back_to_back state=%0d got %b required %b", st - 1, obs, exp_v);
      end
      if (k < FRAME && anodo !== 4'hF) begin
        tests++;
        if (seg !== 7'b0000110) begin
          failed++;
          $display("FAIL b2b_frame_3333 state=%0d got seg %b required 0000110", st - 1, seg);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    while (st % SD != 5) step(1'b0, valor, modo_hex, blank_zeros, pontos);
    rst_n = 1'b0;
    #1;
    obs = {frame_done, seg, dp, anodo};
    tests++;
    if (obs !== {1'b0, 7'h7F, 1'b1, 4'hF}) begin
      failed++;
      $display("FAIL async_reset got %b required %b", obs, {1'b0, 7'h7F, 1'b1, 4'hF});
    end
    @(negedge clk);
    release_reset();
    for (int k = 0; k < FRAME + 8; k++) begin
      step(1'b0, valor, modo_hex, blank_zeros, pontos);
      exp_v = exp_out(st - 1);
      obs = {frame_done, seg, dp, anodo};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL after_reset state=%0d got %b required %b", st - 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12 * FRAME; k++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      else
        step(1'b0, valor, modo_hex, blank_zeros, pontos);
      exp_v = exp_out(st - 1);
      obs = {frame_done, seg, dp, anodo};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL random state=%0d got %b required %b", st - 1, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bcd();
    test_hex_blank();
    test_zero_dp();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/display_mux_7seg.md
# display_mux_7seg

Parametrised, time-multiplexed driver for a bank of 7-segment digits sharing one segment bus. It accepts a packed multi-digit value, decodes each nibble in BCD or hexadecimal mode, blanks leading zeros, drives per-digit decimal points, and scans the digits with an inter-digit blanking gap. It sits between the datapath (which presents values to display) and the board display pins, and replaces the per-digit combinational decoder for multi-digit displays.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8
- SCAN_DIV, 50000, clock cycles per digit slot; must be ≥ 2
- BLANK_CYC, 100, cycles at the start of each slot with all anodes off; must be < SCAN_DIV
- SEG_ACT_LOW, 1, 1 means segment and decimal-point outputs are active-low
- AN_ACT_LOW, 1, 1 means anode outputs are active-low
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- valor  in  4*NUM_DIGITS  packed digits; nibble i is digit i, and digit 0 is least significant
- load  in  1  one-cycle strobe that captures valor, modo_hex, blank_zeros and pontos
- modo_hex  in  1  1 selects hex decoding (0-F); 0 selects BCD, where nibbles 10-15 show blank
- blank_zeros  in  1  1 enables leading-zero blanking
- pontos  in  NUM_DIGITS  decimal point request per digit
- seg  out  7  segments a[6] b[5] c[4] d[3] e[2] f[1] g[0]
- dp  out  1  decimal point
- anodo  out  NUM_DIGITS  digit enables, one-hot while a digit is lit
- frame_done  out  1  one-cycle pulse at the end of each full scan

## Operation
- Two register sets:
  - **pending**: written on every load. If several loads occur in one frame, the last one wins.
  - **active**: drives the display. It is updated from pending only at a frame boundary, and only if a load occurred during that frame, so a frame is never displayed torn between two values.
- Prescaler `pre` counts 0..SCAN_DIV-1. Digit index `idx` advances when `pre` = SCAN_DIV-1, and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: `pre` = SCAN_DIV-1 and `idx` = NUM_DIGITS-1.
  - frame_done is asserted in the following cycle.
  - active ← pending if a load was flagged in this frame.
  - If load is high in the boundary cycle itself, the value on the inputs in that cycle goes directly into active, bypassing pending.
- Decode, with segment set shown active-high as a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Blank = 0000000
- Leading-zero blanking: when blank_zeros=1, digit i is blanked if it and every digit above it are 0. Digit 0 is never blanked.
- Decimal point: dp for digit i comes from pontos[i] regardless of blanking.
- Output polarity: seg and dp are inverted when SEG_ACT_LOW=1; anodo is inverted when AN_ACT_LOW=1.
- Anode gating: anodo[idx] is lit only when `pre` ≥ BLANK_CYC; otherwise every anode is off.

## Timing
- Reset values:
  - pre=0, idx=0, frame_done=0
  - pending and active cleared to all fields 0, load flag clear
  - seg and dp at the off level (seg=7'h7F, dp=1 with default parameters)
  - anodo all off (all 1s with default parameters)
- All outputs are registered, with 1-cycle latency from the (idx, pre) state to seg, dp and anodo.
- Per-slot timing: BLANK_CYC cycles dark, then SCAN_DIV-BLANK_CYC cycles lit. Frame length = NUM_DIGITS·SCAN_DIV cycles.
- Latency from load to display: from the first frame boundary after the load, plus 1 cycle.
- Reset asserted mid-scan: outputs reach their off levels immediately (asynchronously). After release, scanning restarts at idx 0 with `pre` = 0.
- NUM_DIGITS=1: idx stays 0, and every slot end is a frame boundary.

## Structure
- Shared package `display_pkg` holds:
  - the SEG_* segment constants for 0-F and blank
  - a `seg_pattern_t` 7-bit typedef
  - the a..g bit-order convention
- Sub-module `seg_decoder` is the combinational nibble + mode → 7-bit active-high pattern decoder. It is instantiated once on the selected nibble. Polarity inversion is applied in the top level.

## Test plan
- Reset then release, with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 → anodo is all off for 3 cycles. anodo=1110 (active-low) is first seen 3 cycles after release. frame_done pulses every 32 cycles.
- load valor=16'h1234, modo_hex=0 → after the next frame boundary, per slot: seg = ~1101101-style patterns for 4, 3, 2, 1 on digits 0..3 respectively.
- valor=16'h00A5, modo_hex=1, blank_zeros=1 → digit 0 shows 5 (~1011011), digit 1 shows A (~1110111), digits 2-3 show blank (7'h7F). With modo_hex=0, digit 1 is also blank.
- valor=16'h0000, blank_zeros=1, pontos=4'b0100 → only digit 0 shows 0. dp is low only during digit 2's lit window.
- Two loads within one frame (16'h1111, then 16'h2222), then a third load coinciding with the boundary cycle (16'h3333) → the next frame shows 3333. No frame ever shows 1111 or a mixture of values.
- Assert rst_n low mid-slot → seg and anodo go to the off level in the same cycle, without waiting for a clock edge.
